// File: rtl/fe_pipe_ctrl.sv
// Fetch/decode pipeline sequencing: merges stall sources, holds flushes across stalls,
// and runs the fence drain / instruction-side invalidate sequence.
module fe_pipe_ctrl #(
    parameter int CNT_W     = 4,
    parameter int DRAIN_MAX = 15
) (
    input  logic       clk,
    input  logic       cpurst,
    input  logic       de_stall,
    input  logic       exe_stall,
    input  logic       memacc_stall,
    input  logic       fet_flush,
    input  logic       branch_predict_err,
    input  logic       mem2wb_exp_ffout,
    input  logic       fence_req,
    input  logic       ex_busy,
    input  logic       mem_busy,
    output logic       pipe_stall,
    output logic       fe2de_clear,
    output logic [1:0] flush_cause,
    output logic       flush_pend,
    output logic       pc_hold,
    output logic       fence_stall,
    output logic       inv_req,
    output logic       fence_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_SYNC  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] DRAIN_LIM = CNT_W'(DRAIN_MAX);

    logic             stall_any;
    logic [1:0]       live_cause;
    logic [1:0]       pend_cause;
    logic [1:0]       pend_nxt;
    logic [1:0]       eff_cause;
    logic             flush_any;
    logic             in_fence;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign stall_any  = de_stall | exe_stall | memacc_stall;
    assign pipe_stall = stall_any;

    // Cause codes are ordered by priority, so a numeric max picks the winner.
    always_comb begin
        live_cause = 2'b00;
        if (mem2wb_exp_ffout)
            live_cause = 2'b11;
        else if (branch_predict_err)
            live_cause = 2'b10;
        else if (fet_flush)
            live_cause = 2'b01;
    end

    assign eff_cause = (pend_cause > live_cause) ? pend_cause : live_cause;
    assign flush_any = (eff_cause != 2'b00);
    assign in_fence  = (state == S_DRAIN) || (state == S_SYNC);

    always_comb begin
        pend_nxt = pend_cause;
        if (!stall_any)
            pend_nxt = 2'b00;
        else if (live_cause != 2'b00)
            pend_nxt = eff_cause;
    end

    // The FSM keeps running under stall; a live or pending flush aborts the fence.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (fence_req && !stall_any && !flush_any) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (flush_any)
                    state_nxt = S_IDLE;
                else if ((!ex_busy && !mem_busy) || (cnt == DRAIN_LIM))
                    state_nxt = S_SYNC;
            end
            S_SYNC: begin
                state_nxt = flush_any ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (cpurst) begin
            state      <= S_IDLE;
            pend_cause <= 2'b00;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            pend_cause <= pend_nxt;
            cnt        <= cnt_nxt;
        end
    end

    assign flush_pend  = (pend_cause != 2'b00);
    assign fe2de_clear = !stall_any && (flush_any || in_fence);
    assign flush_cause = stall_any ? 2'b00 : eff_cause;
    assign pc_hold     = in_fence;
    assign fence_stall = in_fence;
    assign inv_req     = (state == S_SYNC) && !flush_any;
    assign fence_done  = (state == S_DONE);

endmodule

// File: tb/tb_fe_pipe_ctrl.sv
// Scenario bench for fe_pipe_ctrl: per-cycle stimulus rows, expected output words
// queued on drive and popped when the outputs are sampled on the falling edge.
module tb_fe_pipe_ctrl;

    logic       clk = 1'b0;
    logic       cpurst, de_stall, exe_stall, memacc_stall;
    logic       fet_flush, branch_predict_err, mem2wb_exp_ffout;
    logic       fence_req, ex_busy, mem_busy;
    logic       pipe_stall, fe2de_clear, flush_pend, pc_hold;
    logic       fence_stall, inv_req, fence_done;
    logic [1:0] flush_cause;
    logic [8:0] outs;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb_q[$];

    localparam int DMAX = 15;

    fe_pipe_ctrl #(.CNT_W(4), .DRAIN_MAX(DMAX)) dut (
        .clk                (clk),
        .cpurst             (cpurst),
        .de_stall           (de_stall),
        .exe_stall          (exe_stall),
        .memacc_stall       (memacc_stall),
        .fet_flush          (fet_flush),
        .branch_predict_err (branch_predict_err),
        .mem2wb_exp_ffout   (mem2wb_exp_ffout),
        .fence_req          (fence_req),
        .ex_busy            (ex_busy),
        .mem_busy           (mem_busy),
        .pipe_stall         (pipe_stall),
        .fe2de_clear        (fe2de_clear),
        .flush_cause        (flush_cause),
        .flush_pend         (flush_pend),
        .pc_hold            (pc_hold),
        .fence_stall        (fence_stall),
        .inv_req            (inv_req),
        .fence_done         (fence_done)
    );

    always #5 clk = ~clk;

    // Output word: {pipe_stall, fe2de_clear, flush_cause[1:0], flush_pend, pc_hold, fence_stall, inv_req, fence_done}
    assign outs = {pipe_stall, fe2de_clear, flush_cause, flush_pend, pc_hold,
                   fence_stall, inv_req, fence_done};

    // Stimulus row: {cpurst, de, exe, memacc, fet, bpe, exp, fence_req, ex_busy, mem_busy}
    task automatic drive(input logic [9:0] s, input logic [8:0] e);
        {cpurst, de_stall, exe_stall, memacc_stall, fet_flush, branch_predict_err,
         mem2wb_exp_ffout, fence_req, ex_busy, mem_busy} = s;
        sb_q.push_back(e);
    endtask

    task automatic do_reset;
        {cpurst, de_stall, exe_stall, memacc_stall, fet_flush, branch_predict_err,
         mem2wb_exp_ffout, fence_req, ex_busy, mem_busy} = 10'b1000000000;
        @(posedge clk); #1;
        cpurst = 1'b0;
    endtask

    task automatic test_reset;
        logic [9:0] st [0:6];
        logic [8:0] ex [0:6];
        logic [8:0] e;
        st = '{10'b0000000000, 10'b0010010000, 10'b1010000000, 10'b0010000000,
               10'b0000000110, 10'b1000000110, 10'b0000000000};
        ex = '{9'b000000000, 9'b100000000, 9'b100010000, 9'b100000000,
               9'b000000000, 9'b010001100, 9'b000000000};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL reset cyc %0d got %b want %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority;
        logic [9:0] st [0:3];
        logic [8:0] ex [0:3];
        logic [8:0] e;
        st = '{10'b0000111000, 10'b0000110000, 10'b0000100000, 10'b0000000000};
        ex = '{9'b011100000, 9'b011000000, 9'b010100000, 9'b000000000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL priority cyc %0d got %b want %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush_hold;
        logic [9:0] st [0:4];
        logic [8:0] ex [0:4];
        logic [8:0] e;
        st = '{10'b0010010000, 10'b0010000000, 10'b0010000000, 10'b0000000000, 10'b0000000000};
        ex = '{9'b100000000, 9'b100010000, 9'b100010000, 9'b011010000, 9'b000000000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL flush_hold cyc %0d got %b want %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cause_merge;
        logic [9:0] st [0:4];
        logic [8:0] ex [0:4];
        logic [8:0] e;
        st = '{10'b0100100000, 10'b0100001000, 10'b0001000000, 10'b0000000000, 10'b0000000000};
        ex = '{9'b100000000, 9'b100010000, 9'b100010000, 9'b011110000, 9'b000000000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL cause_merge cyc %0d got %b want %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fence_drain;
        logic [9:0] st [0:7];
        logic [8:0] ex [0:7];
        logic [8:0] e;
        st = '{10'b0000000110, 10'b0000000110, 10'b0100000110, 10'b0000000110,
               10'b0000000100, 10'b0000000100, 10'b0000000000, 10'b0000000000};
        ex = '{9'b000000000, 9'b010001100, 9'b100001100, 9'b010001100,
               9'b010001100, 9'b010001110, 9'b000000001, 9'b000000000};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL fence_drain cyc %0d got %b want %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // ex_busy never drops: SYNC must appear DMAX+1 cycles after the first DRAIN cycle.
    task automatic test_fence_timeout;
        logic [9:0] s;
        logic [8:0] w;
        logic [8:0] e;
        do_reset();
        for (int i = 0; i < DMAX + 5; i++) begin
            s = 10'b0000000110;
            if (i == 0)
                w = 9'b000000000;
            else if (i <= DMAX + 1)
                w = 9'b010001100;
            else if (i == DMAX + 2)
                w = 9'b010001110;
            else if (i == DMAX + 3) begin
                w = 9'b000000001;
                s = 10'b0000000000;
            end else begin
                w = 9'b000000000;
                s = 10'b0000000000;
            end
            drive(s, w);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL fence_timeout cyc %0d got %b want %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fence_abort;
        logic [9:0] st [0:9];
        logic [8:0] ex [0:9];
        logic [8:0] e;
        st = '{10'b0000000110, 10'b0000000110, 10'b0000001110, 10'b0000000010, 10'b0000000000,
               10'b0000000100, 10'b0000000100, 10'b0000100000, 10'b0000000000, 10'b0000000000};
        ex = '{9'b000000000, 9'b010001100, 9'b011101100, 9'b000000000, 9'b000000000,
               9'b000000000, 9'b010001100, 9'b010101100, 9'b000000000, 9'b000000000};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL fence_abort cyc %0d got %b want %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    // Fence waits out a stall and a pending flush, then runs; a held fence_req is ignored mid-sequence.
    task automatic test_back_to_back;
        logic [9:0] st [0:7];
        logic [8:0] ex [0:7];
        logic [8:0] e;
        st = '{10'b0100100100, 10'b0100000100, 10'b0000000100, 10'b0000000100,
               10'b0000000100, 10'b0000000100, 10'b0000000000, 10'b0000000000};
        ex = '{9'b100000000, 9'b100010000, 9'b010110000, 9'b000000000,
               9'b010001100, 9'b010001110, 9'b000000001, 9'b000000000};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(st[i], ex[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            checks++;
            if (outs !== e) begin
                errors++;
                $display("[TB] FAIL back_to_back cyc %0d got %b want %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        {cpurst, de_stall, exe_stall, memacc_stall, fet_flush, branch_predict_err,
         mem2wb_exp_ffout, fence_req, ex_busy, mem_busy} = 10'b1000000000;
        @(posedge clk); #1;
        test_reset();
        test_priority();
        test_flush_hold();
        test_cause_merge();
        test_fence_drain();
        test_fence_timeout();
        test_fence_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
